// File: rtl/ctr_drbg_generate.sv
// CTR_DRBG generate stage: streams enc(key, V+i) blocks, then post-updates key/V with
// the additional input and tracks requests since the last reseed.
module ctr_drbg_generate #(
   parameter int unsigned NB_W         = 8,
   parameter int unsigned CTR_LEN      = 32,
   parameter int unsigned RESEED_W     = 16,
   parameter int unsigned RESEED_LIMIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NB_W-1:0]   num_blocks,
   input  logic [255:0]      key_in,
   input  logic [127:0]      v_in,
   input  logic [383:0]      adin,
   input  logic              reseed,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [127:0]      out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [255:0]      key_out,
   output logic [127:0]      v_out,
   output logic              reseed_required,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, GEN, UPD} state_t;

   state_t                state, state_nx;
   logic [255:0]          key_r;
   logic [255:0]          adin_r;
   logic [127:0]          v_w;
   logic [NB_W-1:0]       rem;
   logic [RESEED_W-1:0]   reseed_ctr;
   logic                  accept;
   logic                  hs;
   logic                  unused_adin;

   // Only the low 256 bits of the additional input feed the post-update.
   assign unused_adin     = ^adin[383:256];
   assign reseed_required = reseed_ctr > RESEED_W'(RESEED_LIMIT);

   function automatic logic [127:0] inc(input logic [127:0] x);
      return {x[127:CTR_LEN], CTR_LEN'(x[CTR_LEN-1:0] + CTR_LEN'(1))};
   endfunction

   function automatic logic [127:0] enc(input logic [255:0] k, input logic [127:0] x);
      return x ^ k[255:128] ^ k[127:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (num_blocks == '0) ? UPD : GEN;
         GEN:     if (hs && rem == NB_W'(1)) state_nx = UPD;
         UPD:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != IDLE);
      accept = (state == IDLE) && start && !reseed_required;
      hs     = (state == GEN) && out_valid && out_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_r      <= '0;
         adin_r     <= '0;
         v_w        <= '0;
         rem        <= '0;
         reseed_ctr <= RESEED_W'(1);
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         key_out    <= '0;
         v_out      <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  key_r  <= key_in;
                  adin_r <= adin[255:0];
                  rem    <= num_blocks;
                  if (num_blocks != '0) begin
                     v_w       <= inc(v_in);
                     out_data  <= enc(key_in, inc(v_in));
                     out_valid <= 1'b1;
                     out_last  <= (num_blocks == NB_W'(1));
                  end else begin
                     v_w <= v_in;
                  end
               end else if (start) begin
                  err <= 1'b1;
               end else if (reseed) begin
                  reseed_ctr <= RESEED_W'(1);
               end
            end
            GEN: begin
               // Output registers only move on a handshake, so they hold under backpressure.
               if (hs) begin
                  if (rem > NB_W'(1)) begin
                     v_w      <= inc(v_w);
                     out_data <= enc(key_r, inc(v_w));
                     out_last <= (rem == NB_W'(2));
                     rem      <= rem - NB_W'(1);
                  end else begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end
               end
            end
            UPD: begin
               key_out <= key_r ^ adin_r;
               v_out   <= v_w ^ adin_r[127:0];
               done    <= 1'b1;
               if (reseed_ctr != '1) reseed_ctr <= reseed_ctr + RESEED_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ctr_drbg_generate.sv
// Self-checking bench for ctr_drbg_generate: directed table, random requests against a
// closed-form model, and hand-written reset / reseed-limit sequences.
module tb_ctr_drbg_generate;
   localparam int unsigned NB_W = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [NB_W-1:0] num_blocks;
   logic [255:0]    key_in;
   logic [127:0]    v_in;
   logic [383:0]    adin;
   logic            reseed;
   logic            out_ready;
   logic            out_valid;
   logic [127:0]    out_data;
   logic            out_last;
   logic            busy;
   logic            done;
   logic [255:0]    key_out;
   logic [127:0]    v_out;
   logic            reseed_required;
   logic            err;

   ctr_drbg_generate dut (
      .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks), .key_in(key_in),
      .v_in(v_in), .adin(adin), .reseed(reseed), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy),
      .done(done), .key_out(key_out), .v_out(v_out), .reseed_required(reseed_required),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] key;
      logic [127:0] v;
      logic [383:0] adin;
      int           n;
      int           stall;
      bit           rnd;
      bit           has_exp;
      logic [127:0] exp_last;
      logic [127:0] exp_vout;
      logic [255:0] exp_kout;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;
   int model_ctr = 1;
   vec_t tbl [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, 384'(act), 384'(exp));
   endtask

   // Block i (1-based) of a request: counter field advanced by i, mod 2^32.
   function automatic logic [127:0] model_v(input logic [127:0] v, input int i);
      logic [31:0] lo;
      lo = v[31:0] + 32'(i);
      return {v[127:32], lo};
   endfunction

   function automatic logic [127:0] model_block(input logic [255:0] k, input logic [127:0] v,
                                                input int i);
      return model_v(v, i) ^ k[255:128] ^ k[127:0];
   endfunction

   function automatic logic [383:0] rand384();
      logic [383:0] r;
      r = '0;
      for (int i = 0; i < 12; i++) r = {r[351:0], 32'($urandom)};
      return r;
   endfunction

   task automatic do_reseed();
      reseed = 1'b1;
      tick();
      reseed = 1'b0;
      model_ctr = 1;
   endtask

   task automatic run_request(input vec_t t);
      int   idx;
      int   cyc;
      bit   r;
      logic [127:0] last_seen;
      if (model_ctr > 16) do_reseed();
      check1("idle_busy", busy, 1'b0);
      check1("reseed_required", reseed_required, model_ctr > 16);
      key_in = t.key; v_in = t.v; adin = t.adin; num_blocks = NB_W'(t.n);
      start = 1'b1;
      tick();
      start = 1'b0;
      idx = 0; cyc = 0; last_seen = '0;
      while (idx < t.n && cyc < 200) begin
         check1("out_valid", out_valid, 1'b1);
         check("out_data", 384'(out_data), 384'(model_block(t.key, t.v, idx + 1)));
         check1("out_last", out_last, idx == t.n - 1);
         check1("done_early", done, 1'b0);
         last_seen = out_data;
         r = (cyc < t.stall) ? 1'b0 : (t.rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         out_ready = r;
         if (t.rnd) begin
            start  = 1'($urandom_range(0, 1));
            reseed = 1'($urandom_range(0, 1));
         end
         tick();
         cyc++;
         if (r) idx++;
      end
      if (idx < t.n) check("stream_timeout", 384'(idx), 384'(t.n));
      start = 1'b0; reseed = 1'b0; out_ready = 1'b1;
      check1("valid_after", out_valid, 1'b0);
      check1("done_before_upd", done, 1'b0);
      check1("busy_upd", busy, 1'b1);
      tick();
      check1("done", done, 1'b1);
      check1("busy_done", busy, 1'b0);
      check("key_out", 384'(key_out), 384'(t.key ^ t.adin[255:0]));
      check("v_out", 384'(v_out), 384'(model_v(t.v, t.n) ^ t.adin[127:0]));
      if (t.has_exp) begin
         check("tbl_v_out", 384'(v_out), 384'(t.exp_vout));
         check("tbl_key_out", 384'(key_out), 384'(t.exp_kout));
         if (t.n > 0) check("tbl_last_block", 384'(last_seen), 384'(t.exp_last));
      end
      model_ctr++;
      tick();
      check1("done_pulse", done, 1'b0);
   endtask

   function automatic vec_t rand_vec(input int n, input bit rnd);
      vec_t t;
      t.key = rand384()[255:0];
      t.v = rand384()[127:0];
      if ($urandom_range(0, 1) == 1) t.v[31:0] = 32'hFFFF_FFFC;
      t.adin = rand384();
      t.n = n; t.stall = 0; t.rnd = rnd; t.has_exp = 1'b0;
      t.exp_last = '0; t.exp_vout = '0; t.exp_kout = '0;
      return t;
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; reseed = 1'b0; out_ready = 1'b1;
      num_blocks = '0; key_in = '0; v_in = '0; adin = '0;

      tbl[0] = '{key: '0, v: '0, adin: '0, n: 3, stall: 0, rnd: 0, has_exp: 1,
                 exp_last: 128'h3, exp_vout: 128'h3, exp_kout: '0};
      tbl[1] = '{key: '0, v: {{24{4'hA}}, 32'hFFFF_FFFE}, adin: '0, n: 2, stall: 0, rnd: 0,
                 has_exp: 1, exp_last: {{24{4'hA}}, 32'h0},
                 exp_vout: {{24{4'hA}}, 32'h0}, exp_kout: '0};
      tbl[2] = '{key: {128'h1, 128'h2}, v: '0, adin: 384'h5, n: 2, stall: 5, rnd: 0,
                 has_exp: 1, exp_last: 128'h1, exp_vout: 128'h7,
                 exp_kout: {128'h1, 128'h7}};
      tbl[3] = '{key: {128'hDEAD, 128'hBEEF}, v: 128'h1234, adin: 384'h3, n: 0, stall: 0,
                 rnd: 0, has_exp: 1, exp_last: '0, exp_vout: 128'h1237,
                 exp_kout: {128'hDEAD, 128'hBEEC}};

      tick(); tick();
      rst = 1'b0;
      tick();
      check1("rst_valid", out_valid, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_err", err, 1'b0);
      check1("rst_reseed_required", reseed_required, 1'b0);
      check("rst_key_out", 384'(key_out), '0);
      check("rst_v_out", 384'(v_out), '0);

      for (int i = 0; i < 4; i++) run_request(tbl[i]);
      for (int i = 0; i < 12; i++) run_request(rand_vec($urandom_range(0, 6), 1'b1));

      // Reset in the middle of a 4-block stream.
      if (model_ctr > 16) do_reseed();
      key_in = rand384()[255:0]; v_in = rand384()[127:0]; adin = rand384();
      num_blocks = NB_W'(4); out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      check1("pre_rst_valid", out_valid, 1'b1);
      rst = 1'b1;
      #1;
      check1("midrst_valid", out_valid, 1'b0);
      check1("midrst_busy", busy, 1'b0);
      check1("midrst_done", done, 1'b0);
      check("midrst_key_out", 384'(key_out), '0);
      check("midrst_v_out", 384'(v_out), '0);
      #1;
      rst = 1'b0;
      model_ctr = 1;
      tick();
      run_request(rand_vec(1, 1'b0));

      // Exhaust the reseed budget; the next start must be rejected.
      while (model_ctr <= 16) run_request(rand_vec(1, 1'b0));
      check1("limit_reseed_required", reseed_required, 1'b1);
      num_blocks = NB_W'(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check1("limit_err", err, 1'b1);
      check1("limit_valid", out_valid, 1'b0);
      check1("limit_busy", busy, 1'b0);
      tick();
      check1("limit_err_pulse", err, 1'b0);
      check1("limit_valid2", out_valid, 1'b0);
      check1("limit_busy2", busy, 1'b0);
      do_reseed();
      check1("reseed_clears", reseed_required, 1'b0);
      run_request(rand_vec(1, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
